latch_fifo: RTL

//  Parametrised FIFO whose storage is DEPTH x WIDTH level-sensitive latches (dlatch cells), not flops.

---
 rtl/latch_fifo_pkg.sv | 32 +++
 rtl/latch_fifo_dlatch_bank.sv | 51 +++++
 rtl/latch_fifo.sv | 107 ++++++++++
 3 files changed

// File: rtl/latch_fifo_pkg.sv
// Shared definitions for the latch-based FIFO: default geometry, pointer/count
// width helpers, the one-hot write-row decoder and the per-cycle operation code.
package latch_fifo_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned MAX_DEPTH = 64;

  // Occupancy update selected by {push, pop}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Pointer width; pointers wrap naturally because DEPTH is a power of two
  function automatic int unsigned addrWidth(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Count needs one extra bit so that "full" (count == DEPTH) is representable
  function automatic int unsigned countWidth(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // One-hot row select for the latch bank; callers truncate to DEPTH bits
  function automatic logic [MAX_DEPTH-1:0] onehot(input int unsigned idx);
    return MAX_DEPTH'(1) << idx;
  endfunction

endpackage

// File: rtl/latch_fifo_dlatch_bank.sv
// Storage array of the latch FIFO: DEPTH rows of WIDTH-bit level-sensitive
// latches sharing one data bus. A row is transparent while its enable is high.
// The active-low reset goes straight to every latch and dominates any write.
module latch_fifo_dlatch_bank #(
  parameter int unsigned      WIDTH  = 8,
  parameter int unsigned      DEPTH  = 4,
  parameter logic [WIDTH-1:0] RVAL   = '0,
  parameter bit               NATIVE = 1'b1
) (
  input  logic                   i_rst,
  input  logic [DEPTH-1:0]       i_en,
  input  logic [WIDTH-1:0]       i_d,
  output logic [DEPTH*WIDTH-1:0] o_q
);

  if (NATIVE) begin : g_nativeRows
    // One independent latch row per entry so each row stays a distinct cell
    for (genvar e = 0; e < DEPTH; e++) begin : g_row
      logic [WIDTH-1:0] r_row;

      // Row latch: reset to RVAL, otherwise follow the shared data while enabled
      always_latch begin
        if (!i_rst) begin
          r_row <= RVAL;
        end else if (i_en[e]) begin
          r_row <= i_d;
        end
      end

      assign o_q[e*WIDTH +: WIDTH] = r_row;
    end
  end else begin : g_flatRows
    logic [DEPTH-1:0][WIDTH-1:0] r_rows;

    // Whole array as one latch process; synthesis may share or merge rows
    always_latch begin
      if (!i_rst) begin
        r_rows <= {DEPTH{RVAL}};
      end else begin
        for (int e = 0; e < DEPTH; e++) begin
          if (i_en[e]) begin
            r_rows[e] <= i_d;
          end
        end
      end
    end

    assign o_q = r_rows;
  end

endmodule

// File: rtl/latch_fifo.sv
// Valid/ready FIFO whose storage is a bank of latches. Pushes are captured in
// flops at the posedge and written into the selected latch row during the
// following low clock phase; the entry becomes readable from the next posedge.
module latch_fifo
  import latch_fifo_pkg::*;
#(
  parameter int unsigned      WIDTH  = DEF_WIDTH,
  parameter int unsigned      DEPTH  = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RVAL   = '0,
  parameter bit               NATIVE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = addrWidth(DEPTH);
  localparam int unsigned CW = countWidth(DEPTH);

  logic [AW-1:0]          r_wrPtr;
  logic [AW-1:0]          r_rdPtr;
  logic [AW-1:0]          r_wAddr;
  logic [WIDTH-1:0]       r_wData;
  logic [CW-1:0]          r_count;
  logic                   r_wrPend;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  fifo_op_e               w_op;
  logic [DEPTH-1:0]       w_sel;
  logic [DEPTH-1:0]       w_en;
  logic [DEPTH*WIDTH-1:0] w_rows;

  // The count includes the entry still being written, so out_valid subtracts it
  assign w_full    = (r_count == CW'(DEPTH));
  assign in_ready  = ~w_full;
  assign w_push    = in_valid & ~w_full;
  assign out_valid = (r_count - CW'(r_wrPend)) != '0;
  assign w_pop     = out_valid & out_ready;
  assign w_op      = fifo_op_e'({w_push, w_pop});

  assign count = r_count;
  assign full  = w_full;
  assign empty = (r_count == '0);

  // Write stage, pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr  <= '0;
      r_rdPtr  <= '0;
      r_wAddr  <= '0;
      r_wData  <= RVAL;
      r_count  <= '0;
      r_wrPend <= 1'b0;
    end else begin
      r_wrPend <= w_push;
      if (w_push) begin
        r_wData <= in_data;
        r_wAddr <= r_wrPtr;
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case (w_op)
        OP_PUSH: r_count <= r_count + CW'(1);
        OP_POP:  r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_sel = DEPTH'(onehot(32'(r_wAddr)));

  // Latch enables open only in the low phase after a push, while r_wData and
  // r_wAddr are held stable, and close at the next posedge
  if (NATIVE) begin : g_nativeGate
    for (genvar e = 0; e < DEPTH; e++) begin : g_row
      assign w_en[e] = ~clk & r_wrPend & w_sel[e];
    end
  end else begin : g_flatGate
    assign w_en = w_sel & {DEPTH{r_wrPend & ~clk}};
  end

  latch_fifo_dlatch_bank #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .RVAL   (RVAL),
    .NATIVE (NATIVE)
  ) u_bank (
    .i_rst (rst),
    .i_en  (w_en),
    .i_d   (r_wData),
    .o_q   (w_rows)
  );

  assign out_data = w_rows[32'(r_rdPtr) * WIDTH +: WIDTH];

endmodule
